// File: rtl/div_iter_if.sv
// Request/result bundle between the EX stage (master) and the iterative divider (slave).
interface div_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   start_i;
    logic                   annul_i;
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   ack_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   busy_o;
    logic                   div_zero_o;
    logic                   overflow_o;

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i, ack_i,
        output result_o, ready_o, busy_o, div_zero_o, overflow_o
    );

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i, ack_i,
        input  result_o, ready_o, busy_o, div_zero_o, overflow_o
    );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring signed/unsigned divider with optional leading-zero early termination.
// Operands are captured on accept; result {remainder, quotient} is held in DONE until ack/annul.
module div_iter #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    div_iter_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic               s1_q, s1_d, s2_q, s2_d;
    logic               dz_q, dz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]   b_q, b_d, dvd_q, dvd_d, rem_q, rem_d, quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d, div_zero_q, div_zero_d, overflow_q, overflow_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [CW-1:0]      lz;
    logic [WIDTH:0]     shifted;

    // Leading-zero count; all-zero input yields WIDTH.
    function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
        lzc = CW'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v[i]) lzc = CW'(int'(WIDTH) - 1 - i);
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        b_d        = b_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        ready_d    = ready_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;

        sa      = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        sb      = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        a_abs   = sa ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
        b_abs   = sb ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;
        lz      = lzc(a_abs);
        shifted = {rem_q, dvd_q[WIDTH-1]};

        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    s1_d  = sa;
                    s2_d  = sb;
                    b_d   = b_abs;
                    rem_d = '0;
                    quo_d = '0;
                    dz_d  = (bus.opdata2_i == '0);
                    ovf_d = bus.signed_div_i && (bus.opdata1_i == MIN_VAL) && (bus.opdata2_i == '1);
                    if (EARLY_TERM) begin
                        dvd_d = a_abs << lz;
                        cnt_d = CW'(WIDTH) - lz;
                    end else begin
                        dvd_d = a_abs;
                        cnt_d = CW'(WIDTH);
                    end
                    if (bus.opdata2_i == '0 || (EARLY_TERM && a_abs == '0)) state_d = FIX;
                    else                                                    state_d = CALC;
                end
            end
            CALC: begin
                if (bus.annul_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    // Restoring step: try subtracting the divisor from the partial remainder.
                    if (shifted >= {1'b0, b_q}) begin
                        rem_d = WIDTH'(shifted - {1'b0, b_q});
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                if (bus.annul_i) begin
                    state_d = IDLE;
                end else begin
                    // Quotient takes sign s1^s2, remainder takes the dividend's sign.
                    if (dz_q) result_d = '0;
                    else      result_d = {(s1_q ? (WIDTH'(0) - rem_q) : rem_q),
                                          ((s1_q ^ s2_q) ? (WIDTH'(0) - quo_q) : quo_q)};
                    ready_d    = 1'b1;
                    div_zero_d = dz_q;
                    overflow_d = ovf_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.ack_i || bus.annul_i) begin
                    result_d   = '0;
                    ready_d    = 1'b0;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            b_q        <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            b_q        <= b_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.div_zero_o = div_zero_q;
    assign bus.overflow_o = overflow_q;
    assign bus.busy_o     = (state_q != IDLE);
endmodule
